// File: rtl/seq_alu_if.sv
// seq_alu request/response bundle.
// Master issues ops; slave is the ALU.
interface seq_alu_if #(
  parameter int W = 8
);
  logic         start;
  logic [2:0]   opcode;
  logic         func;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic         ready;
  logic         done;
  logic [W-1:0] alu_out;
  logic         carry_out;
  logic         branch_taken;
  logic         branch_skip;
  logic         halt;

  modport master (
    output start, opcode, func, input_a, input_b,
    input  ready, done, alu_out, carry_out,
    input  branch_taken, branch_skip, halt
  );

  modport slave (
    input  start, opcode, func, input_a, input_b,
    output ready, done, alu_out, carry_out,
    output branch_taken, branch_skip, halt
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle parametrised ALU: single-cycle ops plus
// iterative 1-bit-per-cycle rotate, with start/ready/done.
module seq_alu #(
  parameter int W       = 8,
  parameter int SHAMT_W = $clog2(W)
) (
  input  logic  Clk,
  input  logic  Reset,
  seq_alu_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ROT = 3'd2;
  localparam logic [2:0] OP_LW  = 3'd3;
  localparam logic [2:0] OP_SW  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_BNE = 3'd7;

  state_t state, state_n;
  logic [W-1:0] work, work_n;
  logic [W-1:0] out_q, out_n;
  logic [SHAMT_W-1:0] cnt, cnt_n, amt;
  logic dir, dir_n;
  logic carry_q, carry_n;
  logic taken_q, taken_n;
  logic skip_q, skip_n;
  logic halt_q, halt_n;
  logic done_q, done_n;
  logic [W:0] sum;
  logic [W-1:0] rot1;

  assign amt  = bus.input_b[SHAMT_W-1:0];
  assign sum  = {1'b0, bus.input_a} + {1'b0, bus.input_b};
  assign rot1 = dir ? {work[0], work[W-1:1]}
                    : {work[W-2:0], work[W-1]};

  assign bus.ready        = (state == IDLE) && !Reset;
  assign bus.done         = done_q;
  assign bus.alu_out      = out_q;
  assign bus.carry_out    = carry_q;
  assign bus.branch_taken = taken_q;
  assign bus.branch_skip  = skip_q;
  assign bus.halt         = halt_q;

  always_comb begin
    state_n = state;
    work_n  = work;
    cnt_n   = cnt;
    dir_n   = dir;
    out_n   = out_q;
    carry_n = carry_q;
    taken_n = taken_q;
    skip_n  = skip_q;
    halt_n  = halt_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.opcode == OP_ROT && amt != '0) begin
            work_n  = bus.input_a;
            cnt_n   = amt;
            dir_n   = bus.func;
            state_n = BUSY;
          end else begin
            done_n  = 1'b1;
            out_n   = '0;
            carry_n = 1'b0;
            taken_n = 1'b0;
            skip_n  = 1'b0;
            halt_n  = 1'b0;
            case (bus.opcode)
              OP_ADD: {carry_n, out_n} = sum;
              OP_MOV: out_n = bus.input_b;
              OP_ROT: begin
                out_n  = bus.input_a;
                halt_n = (bus.input_b == '0);
              end
              OP_SW:  out_n = bus.input_a;
              OP_XOR: out_n = bus.input_a ^ bus.input_b;
              OP_AND: out_n = bus.input_a & bus.input_b;
              OP_BNE: begin
                taken_n = (bus.input_a != bus.input_b);
                skip_n  = (bus.input_a == bus.input_b);
              end
              default: out_n = '0;
            endcase
          end
        end
      end
      BUSY: begin
        work_n = rot1;
        cnt_n  = cnt - 1'b1;
        if (cnt == 1) begin
          out_n   = rot1;
          carry_n = 1'b0;
          taken_n = 1'b0;
          skip_n  = 1'b0;
          halt_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      dir     <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      taken_q <= 1'b0;
      skip_q  <= 1'b0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      work    <= work_n;
      cnt     <= cnt_n;
      dir     <= dir_n;
      out_q   <= out_n;
      carry_q <= carry_n;
      taken_q <= taken_n;
      skip_q  <= skip_n;
      halt_q  <= halt_n;
      done_q  <= done_n;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed cases, random ops,
// and a reset abort mid-rotation.
module tb_seq_alu;
  localparam int W = 8;

  logic Clk = 1'b0;
  logic Reset;

  seq_alu_if #(.W(W)) bus ();

  seq_alu #(.W(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] out;
    logic       c;
    logic       t;
    logic       s;
    logic       h;
    int         edge_n;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge Clk) cyc++;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic from the op definitions.
  function automatic exp_t model(logic [2:0] op, logic f,
                                 logic [7:0] a, logic [7:0] b);
    exp_t r;
    int ai, bi, n, s;
    ai = a;
    bi = b;
    n  = bi % W;
    r.out = 8'h00;
    r.c = 0;
    r.t = 0;
    r.s = 0;
    r.h = 0;
    r.edge_n = 0;
    case (op)
      3'd0: begin
        s = ai + bi;
        r.out = 8'(s % 256);
        r.c = (s > 255);
      end
      3'd1: r.out = b;
      3'd2: begin
        if (n == 0) begin
          r.out = a;
          r.h = (bi == 0);
        end else begin
          if (f)
            s = (ai >> n) | (ai << (W - n));
          else
            s = (ai << n) | (ai >> (W - n));
          r.out = 8'(s % 256);
          r.edge_n = n;
        end
      end
      3'd3: r.out = 8'h00;
      3'd4: r.out = a;
      3'd5: r.out = a ^ b;
      3'd6: r.out = a & b;
      default: begin
        r.t = (a != b);
        r.s = (a == b);
      end
    endcase
    return r;
  endfunction

  task automatic issue(logic [2:0] op, logic f,
                       logic [7:0] a, logic [7:0] b);
    exp_t e;
    int w;
    w = 0;
    @(negedge Clk);
    while (!bus.ready && w < 100) begin
      @(negedge Clk);
      w++;
    end
    if (!bus.ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end else begin
      bus.start   = 1'b1;
      bus.opcode  = op;
      bus.func    = f;
      bus.input_a = a;
      bus.input_b = b;
      e = model(op, f, a, b);
      e.edge_n = cyc + 1 + e.edge_n;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge Clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    idle();
    while (q.size() != 0 && w < 50) begin
      @(negedge Clk);
      w++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_out"}, bus.alu_out, 0);
    chk({tag, "_flags"},
        {bus.carry_out, bus.branch_taken, bus.branch_skip,
         bus.halt, bus.done}, 0);
  endtask

  // Monitor: pops on done, otherwise outputs must hold.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (!Reset) begin
        if (bus.done) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_done actual=1 expected=0");
          end else begin
            e = q.pop_front();
            chk("done_edge", cyc, e.edge_n);
            chk("alu_out", bus.alu_out, e.out);
            chk("flags",
                {bus.carry_out, bus.branch_taken,
                 bus.branch_skip, bus.halt},
                {e.c, e.t, e.s, e.h});
            held = e;
          end
        end else begin
          chk("hold_out", bus.alu_out, held.out);
          chk("hold_flags",
              {bus.carry_out, bus.branch_taken,
               bus.branch_skip, bus.halt},
              {held.c, held.t, held.s, held.h});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    logic [7:0] a, b;
    held = '{default: 0};
    Reset = 1'b1;
    bus.start = 1'b0;
    bus.opcode = 3'd0;
    bus.func = 1'b0;
    bus.input_a = 8'h00;
    bus.input_b = 8'h00;
    repeat (2) @(negedge Clk);
    chk("reset_ready", bus.ready, 0);
    chk_zero("reset");
    Reset = 1'b0;
    #1;
    chk("post_reset_ready", bus.ready, 1);

    issue(3'd0, 1'b0, 8'hF0, 8'h20);
    issue(3'd5, 1'b0, 8'hAA, 8'hFF);
    issue(3'd2, 1'b0, 8'hB3, 8'd3);
    @(negedge Clk);
    chk("busy_ready", bus.ready, 0);
    issue(3'd2, 1'b1, 8'hB3, 8'd1);
    issue(3'd2, 1'b0, 8'h5A, 8'h00);
    issue(3'd2, 1'b1, 8'h5A, 8'h08);
    issue(3'd7, 1'b0, 8'h11, 8'h11);
    issue(3'd7, 1'b0, 8'h11, 8'h12);
    drain();
    chk("bne_taken_last", bus.branch_taken, 1);
    chk("bne_skip_last", bus.branch_skip, 0);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) b = b & 8'h0F;
      if ($urandom_range(0, 7) == 0) b = a;
      issue(op, 1'($urandom), a, b);
      if ($urandom_range(0, 3) == 0) idle();
    end
    drain();

    issue(3'd2, 1'b0, 8'h81, 8'd7);
    @(negedge Clk);
    bus.start = 1'b1;
    bus.opcode = 3'd0;
    bus.input_a = 8'h01;
    bus.input_b = 8'h02;
    @(negedge Clk);
    bus.start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    q.delete();
    held = '{default: 0};
    @(negedge Clk);
    chk("abort_ready", bus.ready, 0);
    chk_zero("abort");
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("abort_idle", bus.ready, 1);
    repeat (12) @(negedge Clk);
    chk_zero("abort_late");
    issue(3'd0, 1'b0, 8'hFF, 8'h01);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
